// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: parametrised single-clock FIFO with synchronous clear,
// optional first-word-fall-through read port, registered fill level,
// programmable almost-full/almost-empty flags and sticky error flags.
module sync_fifo_flex #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_wr_en,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  output logic                    o_full,
  output logic                    o_almost_full,
  input  logic                    i_rd_en,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_empty,
  output logic                    o_almost_empty,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_overflow,
  output logic                    o_underflow
);

  localparam int ADDR = $clog2(DEPTH);
  localparam int LW   = ADDR + 1;

  localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL  = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] LVL_AEMPTY = LW'(AEMPTY_THRESH);
  localparam logic [LW-1:0] ONE        = LW'(1);

  // Storage; contents are deliberately left unreset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit; level is tracked separately so the
  // FWFT output register can be counted as part of the occupancy.
  logic [ADDR:0] wr_ptr;
  logic [ADDR:0] rd_ptr;
  logic [ADDR:0] level;

  logic wr_accept;
  logic rd_accept;
  logic mem_nonempty;
  logic fetch;

  // Status flags are pure functions of registered state.
  assign o_level        = level;
  assign o_full         = (level == LVL_FULL);
  assign o_almost_full  = (level >= LVL_AFULL);
  assign o_almost_empty = (level <= LVL_AEMPTY);
  assign o_empty        = (FWFT != 0) ? !o_rd_valid : (level == '0);

  // A clear in the same cycle overrides any read or write request.
  assign wr_accept    = i_wr_en && !o_full  && !i_clr;
  assign rd_accept    = i_rd_en && !o_empty && !i_clr;
  assign mem_nonempty = (wr_ptr != rd_ptr);

  // fetch = a word leaves the memory array this cycle. In standard mode that
  // is every accepted read; in FWFT mode it refills the output register
  // whenever it is empty or being popped and the array has something.
  assign fetch = (FWFT != 0) ? (mem_nonempty && (!o_rd_valid || rd_accept) && !i_clr)
                             : rd_accept;

  // Array write port.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDR-1:0]] <= i_wr_data;
    end
  end

  // Write and read pointers, both cleared by reset or i_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (fetch) begin
        rd_ptr <= rd_ptr + ONE;
      end
    end
  end

  // Occupancy: moves only on accepted writes/reads, never on prefetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (i_clr) begin
      level <= '0;
    end else begin
      case ({wr_accept, rd_accept})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

  // Read data register: one-cycle strobe in standard mode, head-of-queue
  // holding register in FWFT mode. Data is kept across i_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else if (i_clr) begin
      o_rd_valid <= 1'b0;
    end else if (fetch) begin
      o_rd_data  <= mem[rd_ptr[ADDR-1:0]];
      o_rd_valid <= 1'b1;
    end else if (FWFT != 0) begin
      if (rd_accept) begin
        o_rd_valid <= 1'b0;
      end
    end else begin
      o_rd_valid <= 1'b0;
    end
  end

  // Sticky error flags, only released by clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_clr) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wr_en && o_full) begin
        o_overflow <= 1'b1;
      end
      if (i_rd_en && o_empty) begin
        o_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: drives a standard-mode and an FWFT-mode FIFO with the
// same stimulus and compares both against queue-based reference models.
module tb_sync_fifo_flex;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr;
  logic wr_en;
  logic rd_en;
  logic [DW-1:0] wr_data;

  logic          s_full, s_afull, s_empty, s_aempty, s_valid, s_ov, s_un;
  logic [DW-1:0] s_data;
  logic [4:0]    s_level;
  logic          f_full, f_afull, f_empty, f_aempty, f_valid, f_ov, f_un;
  logic [DW-1:0] f_data;
  logic [4:0]    f_level;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] sq[$];
  logic [DW-1:0] fq[$];
  int            ft[$];
  int            edge_no = 0;
  logic          m_s_ov, m_s_un, m_f_ov, m_f_un;
  logic [DW-1:0] m_s_data;
  logic          m_s_valid;

  always #5 clk = ~clk;

  sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .i_clr(clr),
    .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(s_full), .o_almost_full(s_afull),
    .i_rd_en(rd_en), .o_rd_data(s_data), .o_rd_valid(s_valid),
    .o_empty(s_empty), .o_almost_empty(s_aempty), .o_level(s_level),
    .o_overflow(s_ov), .o_underflow(s_un)
  );

  sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .i_clr(clr),
    .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(f_full), .o_almost_full(f_afull),
    .i_rd_en(rd_en), .o_rd_data(f_data), .o_rd_valid(f_valid),
    .o_empty(f_empty), .o_almost_empty(f_aempty), .o_level(f_level),
    .o_overflow(f_ov), .o_underflow(f_un)
  );

  // In FWFT mode the head word is visible once it has sat in the FIFO for at
  // least one edge after the edge that wrote it.
  function automatic bit fw_vis();
    return (fq.size() > 0) && (ft[0] < edge_no);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    sq.delete(); fq.delete(); ft.delete();
    m_s_ov = 1'b0; m_s_un = 1'b0; m_f_ov = 1'b0; m_f_un = 1'b0;
    m_s_data = '0; m_s_valid = 1'b0;
  endtask

  task automatic checkOutput();
    int sl = sq.size();
    int fl = fq.size();
    bit fv = fw_vis();
    check("std_level",  s_level,  sl);
    check("std_full",   s_full,   sl == DEPTH);
    check("std_afull",  s_afull,  sl >= DEPTH - 2);
    check("std_empty",  s_empty,  sl == 0);
    check("std_aempty", s_aempty, sl <= 2);
    check("std_valid",  s_valid,  m_s_valid);
    check("std_data",   s_data,   m_s_data);
    check("std_ovf",    s_ov,     m_s_ov);
    check("std_unf",    s_un,     m_s_un);
    check("fw_level",   f_level,  fl);
    check("fw_full",    f_full,   fl == DEPTH);
    check("fw_afull",   f_afull,  fl >= DEPTH - 2);
    check("fw_empty",   f_empty,  !fv);
    check("fw_aempty",  f_aempty, fl <= 2);
    check("fw_valid",   f_valid,  fv);
    if (fv) check("fw_data", f_data, fq[0]);
    check("fw_ovf",     f_ov,     m_f_ov);
    check("fw_unf",     f_un,     m_f_un);
  endtask

  // One clock of stimulus; the model steps from its pre-edge state.
  task automatic applyStimulus(input logic wr, input logic [DW-1:0] d,
                               input logic rd, input logic c);
    bit s_wa, s_ra, f_wa, f_ra, fv;
    wr_en = wr; wr_data = d; rd_en = rd; clr = c;
    fv   = fw_vis();
    s_wa = wr && (sq.size() < DEPTH) && !c;
    s_ra = rd && (sq.size() > 0) && !c;
    f_wa = wr && (fq.size() < DEPTH) && !c;
    f_ra = rd && fv && !c;
    @(posedge clk);
    #1;
    edge_no++;
    if (c) begin
      m_s_ov = 1'b0; m_s_un = 1'b0; m_f_ov = 1'b0; m_f_un = 1'b0;
    end else begin
      m_s_ov = m_s_ov | (wr && sq.size() == DEPTH);
      m_s_un = m_s_un | (rd && sq.size() == 0);
      m_f_ov = m_f_ov | (wr && fq.size() == DEPTH);
      m_f_un = m_f_un | (rd && !fv);
    end
    m_s_valid = s_ra;
    if (s_ra) m_s_data = sq.pop_front();
    if (s_wa) sq.push_back(d);
    if (f_ra) begin
      void'(fq.pop_front());
      void'(ft.pop_front());
    end
    if (f_wa) begin
      fq.push_back(d);
      ft.push_back(edge_no);
    end
    if (c) begin
      sq.delete(); fq.delete(); ft.delete();
    end
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; wr_data = '0;
    rst_n = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput();
    check("rst_fw_data", f_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with 0x00..0x0F
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 12) check("afull_below", s_afull, 0);
      if (i == 13) check("afull_at14", s_afull, 1);
    end
    check("fill_full", s_full, 1);
    check("fill_level", s_level, 16);

    // Write while full
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_set", s_ov, 1);
    check("ovf_level", s_level, 16);

    // Drain in order
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_data", s_data, i);
      check("drain_valid", s_valid, 1);
    end
    check("drain_empty", s_empty, 1);

    // Read while empty, then clear
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_set", s_un, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", s_ov, 0);
    check("clr_unf", s_un, 0);

    // Simultaneous write+read when full and at level 5
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hCC, 1'b1, 1'b0);
    check("wrrd_full_level", s_level, 15);
    check("wrrd_full_ovf", s_ov, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hDD, 1'b1, 1'b0);
    check("wrrd_5_level", s_level, 5);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // FWFT latency and back-to-back pops
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    check("fw_lat_n", f_valid, 0);
    check("std_write_empty", s_empty, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check("fw_lat_n1_valid", f_valid, 1);
    check("fw_lat_n1_data", f_data, 8'h5A);
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    check("fw_head", f_data, 8'h5A);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      if (k < 3) check("fw_b2b_data", f_data, k + 1);
      else       check("fw_b2b_empty", f_empty, 1);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Clear mid-stream at level 7
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    check("mid_level7", s_level, 7);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1);
    check("midclr_s_level", s_level, 0);
    check("midclr_f_level", f_level, 0);
    check("midclr_f_empty", f_empty, 1);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check("postclr_fw_data", f_data, 8'h33);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check("postclr_s_data", s_data, 8'h33);

    // Randomised traffic, write-biased then read-biased
    for (int i = 0; i < 600; i++) begin
      int wp = (i < 300) ? 70 : 30;
      applyStimulus($urandom_range(0, 99) < wp, 8'($urandom),
                    $urandom_range(0, 99) < (100 - wp),
                    $urandom_range(0, 63) == 0);
    end

    // Async reset at level 9, between edges
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    check("pre_rst_level", s_level, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_s_level", s_level, 0);
    check("arst_f_level", f_level, 0);
    check("arst_s_empty", s_empty, 1);
    check("arst_f_empty", f_empty, 1);
    check("arst_s_aempty", s_aempty, 1);
    check("arst_f_valid", f_valid, 0);
    check("arst_s_data", s_data, 0);
    check("arst_f_data", f_data, 0);
    resetModel();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    check("post_rst_level", s_level, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised synchronous FIFO with clear. It is the successor of the team's basic sync FIFO and adds a selectable first-word-fall-through (FWFT) read mode, a registered fill level, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a read-valid strobe. It is used as the general-purpose buffer between streaming blocks sharing one clock.

Parameters:
DATA_WIDTH, 8, data word width (>=1)
DEPTH, 16, total storage in words; power of two, >=2
FWFT, 0, 0 = standard 1-cycle read latency; 1 = head word presented on o_rd_data before read
AFULL_THRESH, DEPTH-2, o_almost_full asserted when level >= this (1..DEPTH)
AEMPTY_THRESH, 2, o_almost_empty asserted when level <= this (0..DEPTH-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
i_clr  in  1  synchronous FIFO clear, highest priority
i_wr_en  in  1  write request
i_wr_data  in  DATA_WIDTH  write data
o_full  out  1  level == DEPTH
o_almost_full  out  1  level >= AFULL_THRESH
i_rd_en  in  1  read request (standard) / pop acknowledge (FWFT)
o_rd_data  out  DATA_WIDTH  read data
o_rd_valid  out  1  o_rd_data holds a valid word (see Behaviour)
o_empty  out  1  no word available to read
o_almost_empty  out  1  level <= AEMPTY_THRESH
o_level  out  $clog2(DEPTH)+1  words held, 0..DEPTH
o_overflow  out  1  sticky: write attempted while full
o_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n=0, async):
  - pointers, level, o_rd_valid, o_rd_data, o_overflow, o_underflow = 0.
  - o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0.
  - Memory contents are not reset.
- Accepted write: i_wr_en && !o_full && !i_clr.
- Accepted read: i_rd_en && !o_empty && !i_clr.
- Flags use the current-cycle registered state. A write while full is rejected even when a read is accepted in the same cycle.
- Level: +1 on accepted write only, -1 on accepted read only, unchanged when both occur. Width never wraps; o_level <= DEPTH always.
- Pointers are ADDR+1 bits wide and wrap modulo 2*DEPTH. Memory is indexed by the low ADDR bits.
- All status outputs are derived from registered state only. No combinational path from any input to any output.
- Standard mode (FWFT=0):
  - Accepted read at edge N: mem[head] appears on o_rd_data after edge N, with o_rd_valid=1 for exactly that one cycle.
  - o_rd_data holds its last value otherwise.
  - o_empty = (level==0).
  - A write to an empty FIFO at edge N makes o_empty=0 after edge N.
- FWFT mode (FWFT=1):
  - A prefetch output register holds the head word. o_rd_valid=1 while it is loaded.
  - o_empty = !o_rd_valid.
  - The output register counts toward o_level; total capacity is DEPTH.
  - A write into an empty FIFO at edge N gives o_rd_valid=1 and the data on o_rd_data after edge N+1.
  - Pop (i_rd_en && o_rd_valid) at edge N: the next word is on o_rd_data after edge N if the memory holds one, else o_rd_valid=0.
  - Back-to-back pops sustain 1 word/cycle.
- Errors:
  - o_overflow set on i_wr_en && o_full && !i_clr.
  - o_underflow set on i_rd_en && o_empty && !i_clr.
  - Both stay set until i_clr or reset. Rejected operations never change state.
- i_clr (synchronous, priority over wr/rd):
  - After the edge: pointers=0, level=0, o_rd_valid=0 (FWFT output register emptied), overflow/underflow=0.
  - o_rd_data is not cleared.
  - In standard mode, a read accepted at the edge before i_clr still yields its o_rd_valid pulse during the i_clr cycle.
- Almost flags are comparisons of the registered level. They change in the same cycle as o_level.

Test Plan:
- Fill/drain, DEPTH=16, FWFT=0: write 0x00..0x0F on 16 consecutive cycles -> o_full=1, o_level=16, o_almost_full from level 14. Read 16 -> data 0x00..0x0F in order, each 1 cycle after its i_rd_en with o_rd_valid; o_empty=1, o_level=0 at end.
- Overflow/underflow: write 0xAA when full -> rejected, o_overflow=1, o_level stays 16. Read when empty -> o_underflow=1. Pulse i_clr -> both flags 0, o_level=0.
- Simultaneous wr+rd when full: o_level=16, wr+rd in one cycle -> read accepted, write rejected, o_level=15, o_overflow=1. Same at level 5 -> both accepted, o_level stays 5.
- FWFT latency, FWFT=1: write 0x5A into empty FIFO at edge N -> o_rd_valid=1 and o_rd_data=0x5A after edge N+1. Write 0x01..0x03 then hold i_rd_en -> 0x5A,0x01,0x02,0x03 on consecutive cycles, then o_empty=1.
- Clear mid-stream: level 7, assert i_clr together with i_wr_en and i_rd_en -> next cycle o_level=0, o_empty=1, no write stored. A subsequent write of 0x33 then a read returns 0x33.
- Async reset mid-operation: deassert rst_n at level 9 between edges -> outputs return to reset values immediately, without waiting for a clock edge. After release, normal fill resumes from level 0.
